// File: rtl/stripe_sensor_emulator.sv
// Optical stripe sensor emulator: tracks pod position one stripe pitch per cycle and
// produces the registered stripe pulse, edge, index and overrun flag. Optional STRIPE_STRETCH_EN.
module stripe_sensor_emulator #(
  parameter int unsigned STRIPE_PITCH_MM  = 30480,
  parameter int unsigned STRIPE_WIDTH_MM  = 102,
  parameter int unsigned MIN_PULSE_CYCLES = 20
) (
  input  logic        clk_200khz,
  input  logic        rst_n,
  input  logic [31:0] position,
  output logic        stripe_out,
  output logic        stripe_edge,
  output logic [15:0] stripe_count,
  output logic        locked,
  output logic        overrun
);

  typedef enum logic [0:0] {StCatchup, StTrack} state_e;

  localparam logic [31:0] Pitch32 = 32'(STRIPE_PITCH_MM);
  localparam logic [32:0] Pitch33 = {1'b0, Pitch32};
  localparam logic [32:0] Pitch2  = {Pitch32, 1'b0};
  localparam logic [32:0] Width33 = 33'(STRIPE_WIDTH_MM);
  // Lowest base at which the 16-bit index is pinned at its saturated value.
  localparam logic [47:0] SatBase = 48'(STRIPE_PITCH_MM) * 48'hFFFF;

  state_e      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [15:0] k_q, k_d;
  logic        stripe_q, stripe_d;
  logic        edge_q, edge_d;
  logic        overrun_q, overrun_d;

  logic [32:0] pos33, base33;
  logic [32:0] fwd_lim, fwd2_lim, back_lim, stripe_lim;
  logic        has_prev, ge_fwd, ge_fwd2, lt_back, lt_base;
  logic        step_fwd, step_back, raw;

  // 33-bit sums so a base near 2^32 never wraps below the position.
  assign pos33      = {1'b0, position};
  assign base33     = {1'b0, base_q};
  assign fwd_lim    = base33 + Pitch33;
  assign fwd2_lim   = base33 + Pitch2;
  assign back_lim   = base33 - Pitch33;
  assign stripe_lim = base33 + Width33;

  assign has_prev = (base33 >= Pitch33);
  assign ge_fwd   = (pos33 >= fwd_lim);
  assign ge_fwd2  = (pos33 >= fwd2_lim);
  assign lt_back  = has_prev && (pos33 < back_lim);
  assign lt_base  = has_prev && (pos33 < base33);

  always_comb begin
    state_d   = state_q;
    overrun_d = overrun_q;
    step_fwd  = 1'b0;
    step_back = 1'b0;
    raw       = 1'b0;
    unique case (state_q)
      StCatchup: begin
        if (ge_fwd) begin
          step_fwd = 1'b1;
        end else begin
          state_d = StTrack;
        end
      end
      StTrack: begin
        raw = (pos33 >= base33) && (pos33 < stripe_lim);
        if (ge_fwd2) begin
          overrun_d = 1'b1;
          step_fwd  = 1'b1;
        end else if (ge_fwd) begin
          step_fwd = 1'b1;
        end else if (lt_back) begin
          overrun_d = 1'b1;
          step_back = 1'b1;
        end else if (lt_base) begin
          step_back = 1'b1;
        end
      end
      default: state_d = StCatchup;
    endcase
  end

  always_comb begin
    base_d = base_q;
    k_d    = k_q;
    if (step_fwd) begin
      base_d = base_q + Pitch32;
      k_d    = (k_q == 16'hFFFF) ? k_q : k_q + 16'd1;
    end else if (step_back) begin
      base_d = base_q - Pitch32;
      // Index stays pinned until base drops back under the saturation point.
      k_d    = ({16'b0, base_d} >= SatBase) ? 16'hFFFF : k_q - 16'd1;
    end
  end

`ifdef STRIPE_STRETCH_EN
  localparam int unsigned CntW = (MIN_PULSE_CYCLES > 1) ? $clog2(MIN_PULSE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad =
    CntW'((MIN_PULSE_CYCLES > 0) ? MIN_PULSE_CYCLES - 1 : 0);

  logic [CntW-1:0] stretch_q, stretch_d;

  always_comb begin
    stretch_d = stretch_q;
    stripe_d  = raw;
    if (stripe_q && (stretch_q != '0)) begin
      stripe_d  = 1'b1;
      stretch_d = stretch_q - 1'b1;
    end else if (!stripe_q && raw) begin
      stretch_d = CntLoad;
    end
  end

  always_ff @(posedge clk_200khz or negedge rst_n) begin
    if (!rst_n) begin
      stretch_q <= '0;
    end else begin
      stretch_q <= stretch_d;
    end
  end
`else
  assign stripe_d = raw;
`endif

  assign edge_d = stripe_d & ~stripe_q;

  always_ff @(posedge clk_200khz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StCatchup;
      base_q    <= '0;
      k_q       <= '0;
      stripe_q  <= 1'b0;
      edge_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      k_q       <= k_d;
      stripe_q  <= stripe_d;
      edge_q    <= edge_d;
      overrun_q <= overrun_d;
    end
  end

  assign stripe_out   = stripe_q;
  assign stripe_edge  = edge_q;
  assign stripe_count = k_q;
  assign locked       = (state_q == StTrack);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_stripe_sensor_emulator.sv
// Scoreboard bench for stripe_sensor_emulator; honours STRIPE_STRETCH_EN like the design.
`timescale 1ns/1ps
module tb_stripe_sensor_emulator;

  localparam int unsigned Pitch    = 30480;
  localparam int unsigned Width    = 102;
  localparam int unsigned MinPulse = 20;

  logic        clk_200khz = 1'b0;
  logic        rst_n      = 1'b0;
  logic [31:0] position   = '0;
  logic        stripe_out, stripe_edge, locked, overrun;
  logic [15:0] stripe_count;

  stripe_sensor_emulator #(
    .STRIPE_PITCH_MM (Pitch),
    .STRIPE_WIDTH_MM (Width),
    .MIN_PULSE_CYCLES(MinPulse)
  ) dut (
    .clk_200khz  (clk_200khz),
    .rst_n       (rst_n),
    .position    (position),
    .stripe_out  (stripe_out),
    .stripe_edge (stripe_edge),
    .stripe_count(stripe_count),
    .locked      (locked),
    .overrun     (overrun)
  );

  always #5 clk_200khz = ~clk_200khz;

  int n_tests = 0;
  int n_fail  = 0;
  logic [19:0] exp_q[$];

  // Behavioural reference: base kept as a wide integer, index derived by division.
  longint m_base;
  int     m_k;
  bit     m_track, m_out, m_ovr;
  int     m_age;
  int     edges, highs;

  function automatic logic [19:0] dut_vec();
    return {stripe_out, stripe_edge, stripe_count, locked, overrun};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_base  = 0;
    m_k     = 0;
    m_track = 0;
    m_out   = 0;
    m_ovr   = 0;
    m_age   = 0;
  endtask

  task automatic model_step(input longint p, output logic [19:0] v);
    bit     raw, out_n, edge_n;
    longint idx;
    raw = m_track && (p >= m_base) && (p < m_base + Width);
    if (!m_track) begin
      if (p >= m_base + Pitch) m_base += Pitch;
      else m_track = 1;
    end else if (p >= m_base + 2 * Pitch) begin
      m_ovr = 1;
      m_base += Pitch;
    end else if (p >= m_base + Pitch) begin
      m_base += Pitch;
    end else if (m_base >= Pitch && p < m_base - Pitch) begin
      m_ovr = 1;
      m_base -= Pitch;
    end else if (p < m_base) begin
      m_base -= Pitch;
    end
    idx = m_base / Pitch;
    m_k = (idx > 65535) ? 65535 : int'(idx);
`ifdef STRIPE_STRETCH_EN
    if (m_out && m_age < MinPulse) out_n = 1;
    else out_n = raw;
    if (out_n) m_age = m_out ? m_age + 1 : 1;
`else
    out_n = raw;
`endif
    edge_n = out_n && !m_out;
    m_out  = out_n;
    v = {out_n, edge_n, m_k[15:0], m_track, m_ovr};
  endtask

  task automatic cycle(input logic [31:0] p);
    logic [19:0] v, e;
    position = p;
    model_step(longint'(p), v);
    exp_q.push_back(v);
    @(posedge clk_200khz);
    #1;
    e = exp_q.pop_front();
    check_eq("cyc", 32'(dut_vec()), 32'(e));
    if (stripe_edge) edges++;
    if (stripe_out) highs++;
  endtask

  task automatic do_reset(input logic [31:0] p);
    position = p;
    rst_n    = 1'b0;
    #3;
    check_eq("rst_vals", 32'(dut_vec()), 32'd0);
    model_reset();
    @(negedge clk_200khz);
    rst_n = 1'b1;
    edges = 0;
    highs = 0;
  endtask

  initial begin
    // Forward sweep from origin across two stripes.
    do_reset(32'd0);
    cycle(32'd0);
    check_eq("lock_1cyc", 32'(locked), 32'd1);
    for (int p = 0; p <= 30700; p++) cycle(32'(p));
    check_eq("fwd_edges", 32'(edges), 32'd2);
    check_eq("fwd_highs", 32'(highs), 32'd203);
    check_eq("fwd_count", 32'(stripe_count), 32'd1);

    // Catch-up from a held far position.
    do_reset(32'd100000);
    for (int i = 0; i < 6; i++) cycle(32'd100000);
    check_eq("cu_count", 32'(stripe_count), 32'd3);
    check_eq("cu_locked", 32'(locked), 32'd1);
    check_eq("cu_stripe", 32'(stripe_out), 32'd0);
    check_eq("cu_ovr", 32'(overrun), 32'd0);

    // Jump of more than one pitch sets sticky overrun.
    do_reset(32'd1000);
    for (int i = 0; i < 3; i++) cycle(32'd1000);
    check_eq("pre_ovr", 32'(overrun), 32'd0);
    cycle(32'd70000);
    check_eq("ovr_set", 32'(overrun), 32'd1);
    check_eq("ovr_cnt1", 32'(stripe_count), 32'd1);
    cycle(32'd70000);
    check_eq("ovr_cnt2", 32'(stripe_count), 32'd2);
    for (int i = 0; i < 5; i++) cycle(32'd70000);
    check_eq("ovr_sticky", 32'(overrun), 32'd1);

    // Reverse motion back across stripe 1.
    do_reset(32'd31000);
    cycle(32'd31000);
    cycle(32'd31000);
    check_eq("rev_cnt_start", 32'(stripe_count), 32'd1);
    edges = 0;
    highs = 0;
    for (int p = 31000; p >= 30000; p--) cycle(32'(p));
    check_eq("rev_highs", 32'(highs), 32'd102);
    check_eq("rev_edges", 32'(edges), 32'd1);
    check_eq("rev_count", 32'(stripe_count), 32'd0);

    // Fast pass: three raw stripe samples, stretched or not.
    do_reset(32'd30630);
    cycle(32'd30630);
    cycle(32'd30630);
    edges = 0;
    highs = 0;
    for (int n = 1; n <= 40; n++) cycle(32'(30630 - 50 * n));
`ifdef STRIPE_STRETCH_EN
    check_eq("fast_highs", 32'(highs), 32'(MinPulse));
`else
    check_eq("fast_highs", 32'(highs), 32'd3);
`endif
    check_eq("fast_edges", 32'(edges), 32'd1);

    // Asynchronous reset while over a stripe.
    do_reset(32'd30400);
    cycle(32'd30400);
    cycle(32'd30480);
    cycle(32'd30490);
    check_eq("pre_rst_high", 32'(stripe_out), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst", 32'(dut_vec()), 32'd0);
    model_reset();
    @(negedge clk_200khz);
    rst_n = 1'b1;
    cycle(32'd30490);
    check_eq("rst_catchup", 32'(locked), 32'd0);
    for (int i = 0; i < 3; i++) cycle(32'd30490);
    check_eq("rst_relock", 32'(locked), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
